// File: rtl/data_rx_rgb565_multi.sv
// data_rx_rgb565_multi
//
// Purpose:
//   RGB565 pixel receiver for the HUB75-style LED panel datapath. It takes one
//   byte per clock from the AL422 frame FIFO and assembles groups of CHANNELS
//   RGB565 pixels, two bytes per pixel. Each pixel is expanded to 6 bits per
//   colour and compared against the current PWM threshold. The 3-bit {B,G,R}
//   results for all channels are presented on rgb together, once per group.
//   The block also generates the panel shift clock and a one-cycle strobe per
//   completed group for the PWM counter and the AL422 read-reset logic.
//
// Parameters:
//   CHANNELS  pixels per group / RGB output triplets, 1..4
//   PWM_BITS  width of pwm_value, 1..6
//
// Ports:
//   in_clk           byte clock, all state on the rising edge
//   in_nrst          asynchronous active-low reset
//   in_data          FIFO byte, one per in_clk cycle
//   line_start       resync pulse; the byte in the next cycle is byte 0 of a group
//   pwm_value        current PWM threshold
//   led_clk          registered panel shift clock (low first half, high second half)
//   pwm_cntr_strobe  one-cycle pulse after each completed group
//   alrst_strobe     identical to pwm_cntr_strobe
//   rgb              colour bits, channel c in [3c+2:3c] as {B,G,R}
//
// Configuration:
//   DATA_RX_BYTE_SWAP_EN  when defined, the first byte of each pixel is the
//                         high byte (big-endian FIFO content); when undefined,
//                         the first byte is the low byte. Timing is identical.

module data_rx_rgb565_multi #(
  parameter int CHANNELS = 2,
  parameter int PWM_BITS = 6
) (
  input  logic                  in_clk,
  input  logic                  in_nrst,
  input  logic [7:0]            in_data,
  input  logic                  line_start,
  input  logic [PWM_BITS-1:0]   pwm_value,
  output logic                  led_clk,
  output logic                  pwm_cntr_strobe,
  output logic                  alrst_strobe,
  output logic [3*CHANNELS-1:0] rgb
);

  localparam int GROUP_LEN = 2 * CHANNELS;
  localparam int PH_W = (GROUP_LEN > 2) ? $clog2(GROUP_LEN) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(GROUP_LEN - 1);
  localparam logic [PH_W-1:0] HIGH_PH = PH_W'(CHANNELS);

  logic [PH_W-1:0]       r_phase;
  logic [PH_W-1:0]       w_phaseNext;
  logic [7:0]            r_firstByte;
  logic [3*CHANNELS-1:0] r_shadow;
  logic [3*CHANNELS-1:0] r_rgb;
  logic [3*CHANNELS-1:0] w_rgbNext;
  logic                  r_ledClk;
  logic                  r_groupDone;
  logic [15:0]           w_pixel;
  logic [5:0]            w_r6;
  logic [5:0]            w_g6;
  logic [5:0]            w_b6;
  logic [2:0]            w_colour;
  logic                  w_transfer;

  // Compare the top PWM_BITS of a 6-bit colour against the threshold.
  // Shifting right by (6 - PWM_BITS) selects x6[5 -: PWM_BITS] while keeping
  // every bit of x6 referenced, so narrow PWM configurations lint cleanly.
  function automatic logic colourBit(input logic [5:0] x6,
                                     input logic [PWM_BITS-1:0] thr);
    return (x6 >> (6 - PWM_BITS)) > 6'(thr);
  endfunction

  // The pixel is completed on odd phases: the held first byte plus the byte
  // arriving now. Which of the two is the high byte depends on FIFO endianness.
`ifdef DATA_RX_BYTE_SWAP_EN
  assign w_pixel = {r_firstByte, in_data};
`else
  assign w_pixel = {in_data, r_firstByte};
`endif

  // Expand 5-bit red/blue to 6 bits by replicating the MSB so that full scale
  // maps to full scale; green is already 6 bits wide.
  assign w_r6 = {w_pixel[15:11], w_pixel[15]};
  assign w_g6 = w_pixel[10:5];
  assign w_b6 = {w_pixel[4:0], w_pixel[4]};

  assign w_colour = {colourBit(w_b6, pwm_value),
                     colourBit(w_g6, pwm_value),
                     colourBit(w_r6, pwm_value)};

  // A transfer happens on the last byte of a group unless a resync arrives
  // in that same cycle, in which case the group is abandoned.
  assign w_transfer = (r_phase == LAST_PH) && !line_start;

  // Next phase: count through the group and wrap; a resync always wins and
  // restarts the group. The rgb candidate is the shadow slots with the final
  // slot replaced by the compare result being produced this very cycle.
  always_comb begin
    w_phaseNext = r_phase + PH_W'(1);
    if (r_phase == LAST_PH) begin
      w_phaseNext = '0;
    end
    if (line_start) begin
      w_phaseNext = '0;
    end
    w_rgbNext = r_shadow;
    w_rgbNext[3*(CHANNELS-1) +: 3] = w_colour;
  end

  // Phase counter and panel shift clock. led_clk is derived from the phase
  // the counter is about to enter, so it is a clean register output that is
  // low for the first half of the group and high for the second half.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_phase  <= '0;
      r_ledClk <= 1'b0;
    end else begin
      r_phase  <= w_phaseNext;
      r_ledClk <= (w_phaseNext >= HIGH_PH);
    end
  end

  // Pixel assembly and comparison. Even phases hold the first byte of a pixel;
  // odd phases drop that pixel's compare result into its shadow slot. Bytes
  // arriving alongside a resync belong to a discarded group and are ignored.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_firstByte <= '0;
      r_shadow    <= '0;
    end else if (!line_start) begin
      if (!r_phase[0]) begin
        r_firstByte <= in_data;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (r_phase == PH_W'(2*c + 1)) begin
          r_shadow[3*c +: 3] <= w_colour;
        end
      end
    end
  end

  // Output register and group strobe. All channels update on the same edge,
  // and the strobe is high for exactly the cycle following that edge.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      r_rgb       <= '0;
      r_groupDone <= 1'b0;
    end else begin
      r_groupDone <= w_transfer;
      if (w_transfer) begin
        r_rgb <= w_rgbNext;
      end
    end
  end

  assign rgb             = r_rgb;
  assign led_clk         = r_ledClk;
  assign pwm_cntr_strobe = r_groupDone;
  assign alrst_strobe    = r_groupDone;

endmodule

// File: doc/data_rx_rgb565_multi.md
# data_rx_rgb565_multi

Parametrised RGB565 pixel receiver for the HUB75-style LED panel datapath. It takes one byte per clock from the AL422 frame FIFO and assembles groups of CHANNELS little-endian RGB565 pixels. Each pixel is compared against the current PWM threshold, and the resulting 3-bit colour vectors for all channels update together. It also drives the panel shift clock and the per-group strobes for the PWM counter and the AL422 read-reset logic.

## Interface
- CHANNELS, 2: pixels per group / RGB output triplets (upper and lower half, etc.); legal 1..4.
- PWM_BITS, 6: width of pwm_value; legal 1..6.
- in_clk  in  1  byte clock; all state on rising edge.
- in_nrst  in  1  reset in_nrst, asynchronous, active-low; clock in_clk.
- in_data  in  8  FIFO byte, one per in_clk cycle.
- line_start  in  1  synchronous resync pulse; the byte in the next cycle is byte 0 of a new group.
- pwm_value  in  PWM_BITS  current PWM threshold.
- led_clk  out  1  registered panel shift clock.
- pwm_cntr_strobe  out  1  one-cycle pulse after each completed group.
- alrst_strobe  out  1  identical to pwm_cntr_strobe.
- rgb  out  3*CHANNELS  colour bits; channel c occupies [3c+2:3c], with the bit order {B,G,R}.

## Operation
- Phase counter phase, width clog2(2*CHANNELS) with a minimum of 1.
  - Counts 0..2*CHANNELS-1 and wraps to 0.
  - line_start=1 forces phase to 0 at the next edge, overriding increment and wrap.
- Byte order: byte 2c is the low byte of pixel c; byte 2c+1 is the high byte.
- Pixel assembly: a low-byte holding register loads on even phases. On odd phase 2c+1, pixel c = {in_data, low_reg}.
- Colour expansion:
  - R6 = {P[15:11], P[15]}
  - G6 = P[10:5]
  - B6 = {P[4:0], P[4]}
- Comparison: each colour bit = (X6[5 -: PWM_BITS] > pwm_value), unsigned, using pwm_value sampled at that same odd-phase edge.
- Compare results go to shadow slot c at the odd-phase edge.
- Transfer: at the edge ending phase 2*CHANNELS-1, when line_start=0:
  - all shadow slots load into rgb simultaneously; the last slot takes its compare result directly.
  - the group_done flag is set.
- Strobes: pwm_cntr_strobe = alrst_strobe = group_done. group_done is high exactly one cycle (the phase-0 cycle after a transfer) and is cleared at the next edge.
- line_start while phase != last:
  - the current partial group is discarded; the byte on in_data that cycle is ignored.
  - shadow slots keep their stale values but are overwritten before the next transfer.
  - rgb holds.
- line_start while phase == last: the transfer is suppressed, rgb holds, and no strobe is produced.
- pwm_value changes mid-group: each pixel uses the value present at its own odd-phase edge.

## Timing
- Reset values: phase=0, low_reg=0, shadow=0, rgb=0, led_clk=0, group_done=0, so both strobes are 0.
- led_clk is registered:
  - low during phases 0..CHANNELS-1, high during phases CHANNELS..2*CHANNELS-1.
  - its rising edge therefore falls mid-group, with rgb stable for CHANNELS cycles beforehand.
  - line_start forces led_clk low in the following cycle.
- Latency: the last byte of a group is sampled at edge E. rgb and the strobes are valid from E until the next transfer edge / for one cycle, respectively.
- Throughput: one group per 2*CHANNELS cycles, with no stalls.
- Reset asserted mid-group: everything returns to reset values immediately. After release, the first byte is treated as byte 0.

## Configuration
- DATA_RX_BYTE_SWAP_EN
  - Defined: byte 2c is the high byte and byte 2c+1 the low byte (big-endian FIFO content).
  - Undefined: little-endian as described in Operation.
  - Timing, strobes and transfer points are identical in both cases.

## Test plan
- Reset then release, CHANNELS=2, 4-cycle groups:
  - led_clk pattern 0,0,1,1 repeating from reset release.
  - first strobe in the cycle after byte 3.
  - rgb=0 until the first transfer.
- Bytes 00,F8,E0,07, pwm_value=0 -> after transfer, rgb[2:0]=3'b001 (red) and rgb[5:3]=3'b010 (green), strobe high one cycle.
- Pixel 0x0841 (R=1, G=2, B=1 → R6=2, G6=2, B6=2): pwm_value=1 -> 3'b111; pwm_value=2 -> 3'b000.
- Assert line_start after byte 1 of a group -> next transfer uses the four bytes that follow, rgb unchanged meanwhile, exactly one strobe per completed group.
- Assert line_start in a phase-3 cycle -> no transfer, no strobe, rgb holds its old value.
- With DATA_RX_BYTE_SWAP_EN defined, bytes F8,00,07,E0, pwm_value=0 -> same result as the second scenario (red, green).
